// File: rtl/inst_mem_loader_if.sv
// Fetch and image-load bus for inst_mem_loader.
//   rom_ce_i/rom_addr_i/rom_data_o : core instruction fetch (data returned same cycle)
//   ld_valid_i/ld_data_i/ld_last_i/ld_ready_o : byte-stream program image load
// master = SoC/core side driving requests, slave = inst_mem_loader.
interface inst_mem_loader_if;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        ld_valid_i;
  logic [7:0]  ld_data_i;
  logic        ld_last_i;
  logic        ld_ready_o;

  modport master (
    output rom_ce_i, rom_addr_i, ld_valid_i, ld_data_i, ld_last_i,
    input  rom_data_o, ld_ready_o
  );

  modport slave (
    input  rom_ce_i, rom_addr_i, ld_valid_i, ld_data_i, ld_last_i,
    output rom_data_o, ld_ready_o
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction-memory responder with boot-time image loader.
// Loads a byte-stream program image into internal word RAM while holding the
// core in reset, then releases the core and serves same-cycle fetch reads.
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   bus          : fetch + load bus (slave modport)
//   cpu_rst_o    : active-high reset to the core (low only in RUN)
//   load_done_o  : image loaded, core running
//   err_o        : image overflowed the RAM
//   word_count_o : number of words written
module inst_mem_loader #(
  parameter int DEPTH_LOG2 = 10,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_mem_loader_if.slave      bus,
  output logic                  cpu_rst_o,
  output logic                  load_done_o,
  output logic                  err_o,
  output logic [DEPTH_LOG2:0]   word_count_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, ERR = 2'd2} state_t;

  state_t              state;
  logic [1:0]          lane;
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [31:0]         asm_word;
  logic [31:0]         mem [DEPTH];

  logic                  accept, full, word_end, wr_en, rd_hit;
  logic [1:0]            slot;
  logic [31:0]           wr_word;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  unused_addr_lsb;

  // ld_ready_o is high exactly while in LOAD, so state stands in for it here.
  assign accept   = (state == LOAD) && bus.ld_valid_i;
  // wr_ptr only reaches 2^DEPTH_LOG2 when every word is written.
  assign full     = wr_ptr[DEPTH_LOG2];
  assign word_end = (lane == 2'd3) || bus.ld_last_i;
  assign wr_en    = accept && !full && word_end;

  // Big-endian puts lane 0 in the top byte: slot = 3 - lane = ~lane.
  assign slot    = BIG_ENDIAN ? ~lane : lane;
  assign wr_word = asm_word | ({24'h0, bus.ld_data_i} << {slot, 3'b000});

  // RAM is never reset; word_count gates what is readable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= LOAD;
      lane           <= 2'd0;
      wr_ptr         <= '0;
      asm_word       <= 32'h0;
      cpu_rst_o      <= 1'b1;
      bus.ld_ready_o <= 1'b1;
      load_done_o    <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (full) begin
              state          <= ERR;
              bus.ld_ready_o <= 1'b0;
              err_o          <= 1'b1;
            end else begin
              if (word_end) begin
                wr_ptr   <= wr_ptr + 1'b1;
                lane     <= 2'd0;
                asm_word <= 32'h0;
              end else begin
                lane     <= lane + 2'd1;
                asm_word <= wr_word;
              end
              if (bus.ld_last_i) begin
                state          <= RUN;
                cpu_rst_o      <= 1'b0;
                bus.ld_ready_o <= 1'b0;
                load_done_o    <= 1'b1;
              end
            end
          end
        end
        RUN:     ;
        ERR:     ;
        default: state <= ERR;
      endcase
    end
  end

  assign word_count_o = wr_ptr;

  // Fetch path: out-of-range or unwritten words read as NOP (0).
  assign rd_idx = bus.rom_addr_i[DEPTH_LOG2+1:2];
  assign rd_hit = bus.rom_ce_i && (state == RUN) &&
                  (bus.rom_addr_i[31:DEPTH_LOG2+2] == '0) &&
                  ({1'b0, rd_idx} < wr_ptr);
  assign bus.rom_data_o = rd_hit ? mem[rd_idx] : 32'h0;

  // Byte offset within a word is irrelevant for word fetches.
  assign unused_addr_lsb = ^bus.rom_addr_i[1:0];
endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce = 1'b0;
  logic [31:0] rom_addr = 32'h0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h0;
  logic        ld_last = 1'b0;

  int n_asserts = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inst_mem_loader_if if_be ();
  inst_mem_loader_if if_le ();
  inst_mem_loader_if if_ov ();

  assign if_be.rom_ce_i = rom_ce;   assign if_be.rom_addr_i = rom_addr;
  assign if_be.ld_valid_i = ld_valid; assign if_be.ld_data_i = ld_data; assign if_be.ld_last_i = ld_last;
  assign if_le.rom_ce_i = rom_ce;   assign if_le.rom_addr_i = rom_addr;
  assign if_le.ld_valid_i = ld_valid; assign if_le.ld_data_i = ld_data; assign if_le.ld_last_i = ld_last;
  assign if_ov.rom_ce_i = rom_ce;   assign if_ov.rom_addr_i = rom_addr;
  assign if_ov.ld_valid_i = ld_valid; assign if_ov.ld_data_i = ld_data; assign if_ov.ld_last_i = ld_last;

  logic        be_cpu_rst, be_done, be_err;
  logic [10:0] be_wc;
  logic        le_cpu_rst, le_done, le_err;
  logic [10:0] le_wc;
  logic        ov_cpu_rst, ov_done, ov_err;
  logic [2:0]  ov_wc;

  inst_mem_loader #(.DEPTH_LOG2(10), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst(rst), .bus(if_be.slave), .cpu_rst_o(be_cpu_rst),
    .load_done_o(be_done), .err_o(be_err), .word_count_o(be_wc));
  inst_mem_loader #(.DEPTH_LOG2(10), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst(rst), .bus(if_le.slave), .cpu_rst_o(le_cpu_rst),
    .load_done_o(le_done), .err_o(le_err), .word_count_o(le_wc));
  inst_mem_loader #(.DEPTH_LOG2(2), .BIG_ENDIAN(1'b1)) u_ov (
    .clk(clk), .rst(rst), .bus(if_ov.slave), .cpu_rst_o(ov_cpu_rst),
    .load_done_o(ov_done), .err_o(ov_err), .word_count_o(ov_wc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one rising edge; returns at posedge+1.
  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_data = b; ld_last = last;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic gap(input logic last);
    ld_valid = 1'b0; ld_last = last;
    @(posedge clk); #1;
    ld_last = 1'b0;
  endtask

  task automatic rd(input logic ce, input logic [31:0] addr);
    rom_ce = ce; rom_addr = addr; #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0; #2; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    #12;
    rd(1'b1, 32'h0);
    check("rst_cpu_rst", 32'(be_cpu_rst), 32'd1);
    check("rst_ready",   32'(if_be.ld_ready_o), 32'd1);
    check("rst_done",    32'(be_done), 32'd0);
    check("rst_err",     32'(be_err), 32'd0);
    check("rst_wc",      32'(be_wc), 32'd0);
    check("rst_rom",     if_be.rom_data_o, 32'h0);
    @(posedge clk); #1; rst = 1'b1;

    // Basic 8-byte load
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
    send(8'h9A, 0); send(8'hBC, 0); send(8'hDE, 0);
    check("a_cpu_rst_before", 32'(be_cpu_rst), 32'd1);
    send(8'hF0, 1);
    check("a_cpu_rst_after", 32'(be_cpu_rst), 32'd0);
    check("a_ready", 32'(if_be.ld_ready_o), 32'd0);
    check("a_done",  32'(be_done), 32'd1);
    check("a_wc",    32'(be_wc), 32'd2);
    rd(1'b1, 32'h0); check("a_addr0", if_be.rom_data_o, 32'h12345678);
    check("a_le_addr0", if_le.rom_data_o, 32'h78563412);
    rd(1'b1, 32'h4); check("a_addr4", if_be.rom_data_o, 32'h9ABCDEF0);
    rd(1'b1, 32'h6); check("a_addr6", if_be.rom_data_o, 32'h9ABCDEF0);
    rd(1'b1, 32'h8); check("a_addr8", if_be.rom_data_o, 32'h0);
    rd(1'b0, 32'h0); check("a_le_ce0", if_le.rom_data_o, 32'h0);
    rd(1'b1, 32'h0001_0000); check("a_addr_hi", if_be.rom_data_o, 32'h0);

    // Partial word
    do_reset();
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 1);
    check("b_wc", 32'(be_wc), 32'd1);
    rd(1'b1, 32'h0); check("b_addr0", if_be.rom_data_o, 32'hAABBCC00);
    check("b_le_addr0", if_le.rom_data_o, 32'h00CCBBAA);
    rd(1'b1, 32'h4); check("b_addr4", if_be.rom_data_o, 32'h0);

    // Valid gaps, plus last with valid low
    do_reset();
    gap(1'b1);
    check("c_last_novalid_cpu_rst", 32'(be_cpu_rst), 32'd1);
    check("c_last_novalid_ready", 32'(if_be.ld_ready_o), 32'd1);
    send(8'h12, 0); gap(0); send(8'h34, 0); gap(1'b1); send(8'h56, 0); gap(0);
    send(8'h78, 0); gap(0); send(8'h9A, 0); gap(0); send(8'hBC, 0); gap(0);
    send(8'hDE, 0); gap(0); send(8'hF0, 1);
    check("c_wc", 32'(be_wc), 32'd2);
    check("c_cpu_rst", 32'(be_cpu_rst), 32'd0);
    rd(1'b1, 32'h0); check("c_addr0", if_be.rom_data_o, 32'h12345678);
    rd(1'b1, 32'h4); check("c_addr4", if_be.rom_data_o, 32'h9ABCDEF0);

    // Overflow on the 4-word instance
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i), 0);
    check("d_wc_full", 32'(ov_wc), 32'd4);
    check("d_err_before", 32'(ov_err), 32'd0);
    check("d_ready_before", 32'(if_ov.ld_ready_o), 32'd1);
    send(8'h10, 0);
    check("d_err", 32'(ov_err), 32'd1);
    check("d_ready", 32'(if_ov.ld_ready_o), 32'd0);
    check("d_cpu_rst", 32'(ov_cpu_rst), 32'd1);
    send(8'hEE, 0); send(8'hFF, 1);
    check("d_err_hold", 32'(ov_err), 32'd1);
    check("d_done_hold", 32'(ov_done), 32'd0);
    check("d_wc_hold", 32'(ov_wc), 32'd4);

    // Reset mid-load, then reload
    do_reset();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    send(8'h44, 0); send(8'h55, 0); send(8'h66, 0);
    check("e_wc_mid", 32'(be_wc), 32'd1);
    rst = 1'b0; #1;
    check("e_async_wc", 32'(be_wc), 32'd0);
    check("e_async_cpu_rst", 32'(be_cpu_rst), 32'd1);
    check("e_async_ready", 32'(if_be.ld_ready_o), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    check("e_wc", 32'(be_wc), 32'd1);
    rd(1'b1, 32'h0); check("e_addr0", if_be.rom_data_o, 32'h01020304);
    rd(1'b1, 32'h4); check("e_addr4_stale", if_be.rom_data_o, 32'h0);
    send(8'h55, 0); send(8'h66, 1);
    check("e_run_wc", 32'(be_wc), 32'd1);
    check("e_run_done", 32'(be_done), 32'd1);
    rd(1'b1, 32'h0); check("e_run_addr0", if_be.rom_data_o, 32'h01020304);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
